fetch_align_buf: RTL

- Sits between the instruction fetch port and the 32-bit/16-bit decoders.
- Accepts aligned 64-bit fetch words and stores them as 16-bit parcels in a circular buffer.
- Realigns the parcels into whole instructions and presents one instruction per cycle, with its PC, to decode over a valid/ready handshake.
- Absorbs redirects (branch, jump, trap, mret) by flushing.

---
 rtl/fetch_align_buf_pkg.sv | 19 +
 rtl/fetch_align_buf_chk.sv | 14 +
 rtl/fetch_align_buf_parcel_fifo.sv | 96 +++++++++
 rtl/fetch_align_buf.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fetch_align_buf_pkg.sv
// Shared types and constants for the fetch alignment buffer.
// A parcel is one 16-bit instruction halfword plus the fault flag of the fetch word it came from.
package fetch_pkg;

    localparam int PARCEL_W          = 16;
    localparam int FETCH_W           = 64;
    localparam int PARCELS_PER_FETCH = 4;

    typedef struct packed {
        logic [PARCEL_W-1:0] data;
        logic                err;
    } parcel_t;

    // A parcel starts a compressed instruction unless its two low bits are both set.
    function automatic logic is_rvc(input parcel_t p);
        return (p.data[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/fetch_align_buf_chk.sv
// Protocol checker: without compressed-instruction support every fetch must start
// on a 32-bit boundary, so fetch_pc[1] must be clear whenever fetch_valid is high.
module fetch_align_buf_chk (
    input logic clk,
    input logic rst_n,
    input logic fetch_valid,
    input logic fetch_pc_b1
);

    a_no_half_offset: assert property (
        @(posedge clk) disable iff (!rst_n) fetch_valid |-> !fetch_pc_b1
    );

endmodule

// File: rtl/fetch_align_buf_parcel_fifo.sv
// Circular parcel store: writes up to four parcels per cycle at tail,
// exposes the two oldest parcels, and pops one or two per cycle.
module parcel_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               wr_en_i,
    input  logic [1:0]         wr_off_i,
    input  logic [FETCH_W-1:0] wr_data_i,
    input  logic               wr_err_i,
    input  logic               rd_en_i,
    input  logic [1:0]         rd_len_i,
    output parcel_t            rd0_o,
    output parcel_t            rd1_o,
    output logic [CW-1:0]      count_o
);

    parcel_t         mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      wr_num_s;
    logic [1:0]      rd_num_s;
    logic            wr_we_s  [PARCELS_PER_FETCH];
    logic [PW-1:0]   wr_idx_s [PARCELS_PER_FETCH];
    logic [1:0]      wr_src_s [PARCELS_PER_FETCH];
    parcel_t         wr_par_s [PARCELS_PER_FETCH];

    // Pointer/count next state; a flush wins over any write or pop.
    always_comb begin
        wr_num_s = wr_en_i ? (3'd4 - {1'b0, wr_off_i}) : 3'd0;
        rd_num_s = rd_en_i ? rd_len_i : 2'd0;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(rd_num_s);
            tail_d  = tail_q + PW'(wr_num_s);
            count_d = count_q + CW'(wr_num_s) - CW'(rd_num_s);
        end
    end

    // Write lanes: lane k stores source parcel off+k at tail+k; lanes past the word end stay idle.
    always_comb begin
        for (int k = 0; k < PARCELS_PER_FETCH; k++) begin
            wr_we_s[k]       = wr_en_i & ~flush_i & (3'(k) < wr_num_s);
            wr_idx_s[k]      = tail_q + PW'(k);
            wr_src_s[k]      = wr_off_i + 2'(k);
            wr_par_s[k].data = wr_data_i[{wr_src_s[k], 4'b0000} +: PARCEL_W];
            wr_par_s[k].err  = wr_err_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Parcel storage; cleared on reset so the head outputs read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < PARCELS_PER_FETCH; k++) begin
                if (wr_we_s[k]) begin
                    mem_q[wr_idx_s[k]] <= wr_par_s[k];
                end
            end
        end
    end

    assign rd0_o   = mem_q[head_q];
    assign rd1_o   = mem_q[head_q + PW'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_align_buf.sv
// Fetch alignment buffer: stores fetch words as parcels, rebuilds whole
// instructions with their PC and hands one per cycle to decode.
// Build option: define FETCH_RVC_EN to support 16-bit compressed instructions;
// when undefined every non-faulting instruction is two parcels long.
module fetch_align_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PC_W  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [FETCH_W-1:0] fetch_data,
    input  logic [PC_W-1:0]    fetch_pc,
    input  logic               fetch_err,
    input  logic               redirect,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst,
    output logic [PC_W-1:0]    inst_pc,
    output logic               inst_rvc,
    output logic               inst_err
);

    localparam int CW = $clog2(DEPTH + 1);

    parcel_t          p0_s, p1_s;
    logic [CW-1:0]    count_s;
    logic             rvc_s;
    logic [1:0]       len_s;
    logic             accept_s;
    logic             consume_s;
    logic             pc_known_q, pc_known_d;
    logic [PC_W-1:0]  head_pc_q, head_pc_d;

    parcel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (redirect),
        .wr_en_i   (accept_s),
        .wr_off_i  (fetch_pc[2:1]),
        .wr_data_i (fetch_data),
        .wr_err_i  (fetch_err),
        .rd_en_i   (consume_s),
        .rd_len_i  (len_s),
        .rd0_o     (p0_s),
        .rd1_o     (p1_s),
        .count_o   (count_s)
    );

`ifndef FETCH_RVC_EN
    fetch_align_buf_chk u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_pc_b1 (fetch_pc[1])
    );
`endif

    // Fetch handshake: room for a whole word, never while flushing.
    always_comb begin
        fetch_ready = (count_s <= CW'(DEPTH - 4)) & ~redirect;
        accept_s    = fetch_valid & fetch_ready;
    end

    // Instruction formation from the two oldest parcels.
    always_comb begin
`ifdef FETCH_RVC_EN
        rvc_s = is_rvc(p0_s);
`else
        rvc_s = 1'b0;
`endif
        inst_valid = (count_s != '0) & (p0_s.err | rvc_s | (count_s >= CW'(2)));
        inst_rvc   = rvc_s;
        inst_pc    = head_pc_q;
        inst       = 32'h0000_0000;
        inst_err   = 1'b0;
        len_s      = 2'd1;
        if (p0_s.err) begin
            inst     = 32'h0000_0000;
            inst_err = 1'b1;
            len_s    = 2'd1;
        end else if (rvc_s) begin
            inst     = {16'h0000, p0_s.data};
            inst_err = 1'b0;
            len_s    = 2'd1;
        end else begin
            inst     = {p1_s.data, p0_s.data};
            inst_err = p1_s.err;
            len_s    = 2'd2;
        end
        consume_s = inst_valid & inst_ready & ~redirect;
    end

    // PC tracking: load from the first word after reset/flush, then advance by consumed length.
    always_comb begin
        pc_known_d = pc_known_q;
        head_pc_d  = head_pc_q;
        if (redirect) begin
            pc_known_d = 1'b0;
        end else if (accept_s && !pc_known_q) begin
            pc_known_d = 1'b1;
            head_pc_d  = fetch_pc;
        end else if (consume_s) begin
            head_pc_d  = head_pc_q + PC_W'({len_s, 1'b0});
        end else begin
            head_pc_d  = head_pc_q;
        end
    end

    // PC state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_known_q <= 1'b0;
            head_pc_q  <= '0;
        end else begin
            pc_known_q <= pc_known_d;
            head_pc_q  <= head_pc_d;
        end
    end

endmodule
